mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter and sequencer for the shared 12-bit-address, 4-bit-data memory bus. Port 0 is the CPU, port 1 is the program loader/debug port. Each port uses a req/gnt/done handshake. The block serialises accesses onto the single synchronous memory and bounds loader bursts so the CPU cannot starve.

## Interface
Parameters:
- ADDR_W, 12, address width
- DATA_W, 4, data width
- BURST_MAX, 4, max consecutive port-1 grants while port 0 waits (must be >= 1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata  out  DATA_W  read data; valid while a done pulse is high for a read
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_addr is sampled
- busy  out  1  high in ACCESS and RESP

## Operation
- Reset values: all outputs 0, state IDLE, owner 0, burst_cnt 0.
- States:
  - IDLE: samples req0/req1.
  - ACCESS: memory samples mem_addr/mem_we/mem_wdata at the end of this cycle.
  - RESP: mem_rdata is valid during this cycle.
- IDLE with no request: stay in IDLE, hold mem_addr, mem_we = 0.
- IDLE with any request: pick a winner and go to ACCESS. Register the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, pulse gnt of the winner, latch owner.
- Winner selection:
  - Only one req high: that port.
  - Both high: port 1, unless burst_cnt == BURST_MAX, in which case port 0.
- burst_cnt update, applied at each grant:
  - Grant to port 1 with req0 high: burst_cnt + 1.
  - Grant to port 0, or grant to port 1 with req0 low: reset to 0.
  - burst_cnt never exceeds BURST_MAX; width is clog2(BURST_MAX+1).
- ACCESS to RESP unconditionally. mem_we drops to 0 on leaving ACCESS, so a write strobe is exactly one cycle.
- RESP to IDLE unconditionally:
  - rdata <= mem_rdata for reads; rdata holds its previous value for writes.
  - done of the owner pulses for reads and writes.
- Requester rules:
  - Hold req/we/addr/wdata stable from assertion until gnt is seen.
  - Signals are ignored while busy.
  - A new request may be presented the cycle after gnt; it is sampled at the next IDLE.
- Reset mid-operation: state returns to IDLE immediately, mem_we and all pulses drop to 0 asynchronously, and no done is issued. The aborted access is lost; the requester must re-request.
- gnt0/gnt1 and done0/done1 are never high at the same time.

## Timing
- Request sampled in IDLE at cycle N:
  - gnt and mem signals valid at N+1 (ACCESS).
  - RESP at N+2.
  - done and rdata at N+3, which is also the next IDLE and arbitration cycle.
- Throughput: one access per 3 cycles. A requester holding req continuously is granted every 3 cycles when uncontested.
- Fairness: with both ports continuously requesting, the grant sequence repeats as BURST_MAX grants to port 1, then 1 grant to port 0.
- Port-0 worst-case wait from req to gnt: 3*(BURST_MAX+1)+1 cycles.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Port-0 read: memory[0x123] = 0xA, req0 = 1, we0 = 0 at cycle 0 -> gnt0 at 1, mem_addr = 0x123 at 1, mem_we = 0, done0 and rdata = 0xA at 3, busy high for cycles 1-2.
- Port-1 write then read: write addr 0xFFF, data 0x5 -> mem_we high only in cycle 1, done1 at 3, rdata unchanged; a following read of 0xFFF returns 0x5.
- Simultaneous req0/req1 at cycle 0, burst_cnt = 0 -> gnt1 at 1, done1 at 3; gnt0 at 4, done0 at 6.
- Burst limit, BURST_MAX = 4, both requesting continuously -> grant order 1,1,1,1,0,1,1,1,1,0; burst_cnt peaks at 4 and returns to 0 after each port-0 grant.
- Async reset asserted mid-cycle during ACCESS of a write -> mem_we, busy and gnt go to 0 without waiting for a clock edge; no done follows; after release, state is IDLE and a fresh req0 completes normally.
- Port 0 alone requesting continuously -> gnt0 at cycles 1, 4, 7, 10; burst_cnt stays 0; gnt1/done1 never pulse.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port req/gnt/done arbiter that serialises CPU (port 0) and loader (port 1)
// accesses onto one synchronous memory, capping loader bursts while the CPU waits.
//
// state  | meaning
// IDLE   | arbitrate; register winner's request onto the memory bus
// ACCESS | memory samples mem_addr/mem_we/mem_wdata at end of cycle
// RESP   | mem_rdata valid; capture read data and pulse owner's done
module mem_bus_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state;
  logic             owner;
  logic             rd_pending;
  logic [CNT_W-1:0] burst_cnt;
  logic             pick1;

  // Loader wins ties until it has taken BURST_MAX grants back to back over a waiting CPU.
  assign pick1 = req1 && (!req0 || (burst_cnt != CNT_MAX));
  assign busy  = (state == S_ACCESS) || (state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      rd_pending <= 1'b0;
      burst_cnt  <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_we <= 1'b0;
          if (req0 || req1) begin
            state <= S_ACCESS;
            owner <= pick1;
            if (pick1) begin
              mem_addr   <= addr1;
              mem_we     <= we1;
              mem_wdata  <= wdata1;
              rd_pending <= !we1;
              gnt1       <= 1'b1;
              burst_cnt  <= req0 ? burst_cnt + CNT_W'(1) : '0;
            end else begin
              mem_addr   <= addr0;
              mem_we     <= we0;
              mem_wdata  <= wdata0;
              rd_pending <= !we0;
              gnt0       <= 1'b1;
              burst_cnt  <= '0;
            end
          end
        end
        S_ACCESS: begin
          mem_we <= 1'b0;
          state  <= S_RESP;
        end
        S_RESP: begin
          if (rd_pending) rdata <= mem_rdata;
          if (owner) done1 <= 1'b1;
          else       done0 <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table for single arbitrations,
// hand sequences for burst fairness, uncontested streaming and async reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [3:0]  wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, mem_we, busy;
  logic [3:0]  rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  mem_bus_arbiter #(.ADDR_W(12), .DATA_W(4), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: rdata one cycle after the address is sampled.
  logic [3:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
    mem[12'h123] = 4'hA;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       port;
    logic [3:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input logic port, input logic [3:0] rd);
    exp_t e;
    e.port  = port;
    e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // Done monitor: every done pulse must match the oldest outstanding grant.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done0 || done1) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", {14'b0, done1, done0}, 16'h0);
        end else begin
          e = sb_q.pop_front();
          check("done_port", {14'b0, done1, done0}, e.port ? 16'h2 : 16'h1);
          check("done_rdata", {12'b0, rdata}, {12'b0, e.rdata});
        end
      end
    end
  end

  typedef struct {
    logic       req0, we0;
    logic [11:0] addr0;
    logic [3:0] wdata0;
    logic       req1, we1;
    logic [11:0] addr1;
    logic [3:0] wdata1;
    logic       exp_p1;
    logic [3:0] exp_rdata;
  } vec_t;
  vec_t vecs[9];

  logic order[10];

  initial begin
    vec_t v;
    logic [11:0] w_addr;
    logic        w_we;
    logic [3:0]  w_wdata;

    vecs[0] = '{1'b1, 1'b0, 12'h123, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'hA};
    vecs[1] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b1, 12'hFFF, 4'h5, 1'b1, 4'hA};
    vecs[2] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 12'hFFF, 4'h0, 1'b1, 4'h5};
    vecs[3] = '{1'b1, 1'b1, 12'h010, 4'h3, 1'b1, 1'b0, 12'h123, 4'h0, 1'b1, 4'hA};
    vecs[4] = '{1'b1, 1'b1, 12'h020, 4'h7, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'hA};
    vecs[5] = '{1'b1, 1'b0, 12'h020, 4'h0, 1'b1, 1'b1, 12'h123, 4'hC, 1'b1, 4'hA};
    vecs[6] = '{1'b1, 1'b0, 12'h123, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'hC};
    vecs[7] = '{1'b1, 1'b0, 12'h020, 4'h0, 1'b1, 1'b0, 12'hFFF, 4'h0, 1'b1, 4'h5};
    vecs[8] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 12'h020, 4'h0, 1'b1, 4'h7};
    for (int i = 0; i < 10; i++) order[i] = (i % 5) != 4;

    #22 rst = 1'b0;
    tick();
    check("reset_outputs",
          {gnt0, gnt1, done0, done1, mem_we, busy, rdata, 6'b0},
          16'h0);
    check("reset_mem_bus", {mem_addr, mem_wdata}, 16'h0);

    // Table-driven single arbitrations; each vector starts on an IDLE cycle.
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
      req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1;
      w_addr  = v.exp_p1 ? v.addr1  : v.addr0;
      w_we    = v.exp_p1 ? v.we1    : v.we0;
      w_wdata = v.exp_p1 ? v.wdata1 : v.wdata0;
      tick();
      check("vec_gnt", {14'b0, gnt1, gnt0}, v.exp_p1 ? 16'h2 : 16'h1);
      check("vec_mem_addr", {4'b0, mem_addr}, {4'b0, w_addr});
      check("vec_mem_we", {15'b0, mem_we}, {15'b0, w_we});
      if (w_we) check("vec_mem_wdata", {12'b0, mem_wdata}, {12'b0, w_wdata});
      check("vec_busy_access", {15'b0, busy}, 16'h1);
      push_exp(v.exp_p1, v.exp_rdata);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check("vec_resp", {13'b0, busy, mem_we, gnt0 | gnt1}, 16'h4);
      tick();
      check("vec_idle_busy", {15'b0, busy}, 16'h0);
    end

    // Both ports streaming reads: four loader grants then one CPU grant.
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'hFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("burst_order", {14'b0, gnt1, gnt0}, order[i] ? 16'h2 : 16'h1);
      push_exp(order[i], order[i] ? 4'h5 : 4'hC);
      if (i == 9) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      tick();
    end

    // CPU alone holding req: grants every third cycle.
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("solo_gnt0", {15'b0, gnt0}, {15'b0, (c % 3) == 1});
      check("solo_port1_quiet", {14'b0, gnt1, done1}, 16'h0);
      if ((c % 3) == 1) push_exp(1'b0, 4'hC);
      if (c == 10) req0 = 1'b0;
    end

    // Async reset during the ACCESS cycle of a write; the access is abandoned.
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h200; wdata0 = 4'h9;
    tick();
    check("rst_pre_we", {14'b0, mem_we, gnt0}, 16'h3);
    req0 = 1'b0; we0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop", {13'b0, mem_we, busy, gnt0}, 16'h0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    check("rst_after_idle", {12'b0, busy, done0, done1, gnt0}, 16'h0);
    check("rst_no_write", {12'b0, mem[12'h200]}, 16'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123;
    tick();
    check("rst_fresh_gnt0", {14'b0, gnt1, gnt0}, 16'h1);
    check("rst_fresh_addr", {4'b0, mem_addr}, 16'h0123);
    push_exp(1'b0, 4'hC);
    req0 = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("sb_drained", 16'(sb_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
